ray_generator: RTL and testbench
================================

RAY_GENERATOR -- requirements
Module: ray_generator

Interface
REQ-001 SHALL have parameter H_RES, default 8, meaning pixels per row, legal range 2..256.
REQ-002 SHALL have parameter V_RES, default 8, meaning rows per frame, legal range 2..256.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning a frame request, sampled only in IDLE.
REQ-006 SHALL have ports cam_x, cam_y, cam_z  input  12 each, signed Q8.4, meaning the camera origin.
REQ-007 SHALL have ports dx0, dy0, dz  input  12 each, signed Q8.4, meaning the direction for pixel (0,0) and the constant z component.
REQ-008 SHALL have ports step_x, step_y  input  12 each, signed Q8.4, meaning the per-pixel direction increment along x and the per-row decrement along y.
REQ-009 SHALL have ports ox, oy, oz, dx, dy, dz_out  output  12 each, signed Q8.4, meaning the ray presented to the intersector.
REQ-010 SHALL have ports px, py  output  8 each, meaning the pixel column and row of the current ray.
REQ-011 SHALL have port ray_valid  output  1  meaning the ray outputs hold a valid ray.
REQ-012 SHALL have port ray_ready  input  1  meaning the downstream block accepts the ray.
REQ-013 SHALL have port ray_last  output  1  meaning the current ray is pixel (H_RES-1, V_RES-1).
REQ-014 SHALL have port busy  output  1  meaning a frame is in progress (state RUN).
REQ-015 SHALL have port done  output  1  meaning a one-cycle pulse after the final transfer.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch cam_x/y/z, dx0, dy0, dz, step_x and step_y, load px=0, py=0, dx=dx0 and dy=dy0, and enter RUN.
REQ-018 In RUN, ray_valid SHALL be 1; the first ray SHALL be valid in the cycle after start is sampled, giving 1-cycle latency.
REQ-019 A transfer SHALL occur on a rising edge where ray_valid=1 and ray_ready=1; ray_valid SHALL NOT depend combinationally on ray_ready.
REQ-020 While ray_valid=1 and ray_ready=0, all ray, px, py and ray_last outputs SHALL be held stable.
REQ-021 On a transfer with px<H_RES-1, the block SHALL set px=px+1 and dx=dx+step_x; py and dy SHALL be unchanged.
REQ-022 On a transfer with px=H_RES-1 and py<V_RES-1, the block SHALL set px=0, dx=dx0 (latched), py=py+1 and dy=dy-step_y.
REQ-023 On a transfer with ray_last=1, the block SHALL enter DONE and deassert ray_valid in the next cycle.
REQ-024 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 ox, oy, oz SHALL equal the latched camera origin; dz_out SHALL equal the latched dz for every ray in the frame.
REQ-026 dx/dy accumulation SHALL use 12-bit two's-complement wrap with no saturation; input changes during RUN SHALL have no effect.
REQ-027 start SHALL be ignored in RUN and DONE; start held high in IDLE SHALL begin a new frame after done.
REQ-028 Back-to-back transfers SHALL sustain one ray per cycle when ray_ready is held at 1.
REQ-029 busy SHALL be 1 exactly in RUN; ray_last SHALL be 1 only when ray_valid=1.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and set ray_valid, busy, done and ray_last to 0, px and py to 0, and all ray outputs to 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL wait for a new start.

Verification
REQ-032 Frame test: H_RES=V_RES=8, dx0=-0x040, dy0=0x040, step_x=step_y=0x010, dz=0x010, ready=1 -> 64 rays on consecutive cycles; ray 9 has px=1, py=1, dx=-0x030, dy=0x030; done pulses 1 cycle after the ray with ray_last.
REQ-033 Backpressure test: drop ray_ready for 3 cycles at pixel (3,2) -> outputs held constant for those 3 cycles, no pixel skipped or duplicated, 64 transfers total.
REQ-034 Row wrap test: at pixel (7,0) transfer -> next ray is px=0, py=1, dx=dx0, dy=dy0-step_y.
REQ-035 Mid-frame reset test: assert rst_n=0 at pixel (4,4) -> all outputs 0 asynchronously; no done pulse; start after release begins again at (0,0).
REQ-036 Start-ignore and wrap test: pulse start and change cam_x during RUN -> no restart and origin unchanged; dx0=0x7F0 with step_x=0x020 -> dx wraps to 0x810 at px=1.

Source files
------------

// File: rtl/ray_generator.sv
// Per-pixel primary-ray generator: walks an H_RES x V_RES frame and presents one
// ray per pixel over a valid/ready handshake, starting from a latched camera setup.
module ray_generator #(
    parameter int H_RES = 8,
    parameter int V_RES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] cam_x,
    input  logic [11:0] cam_y,
    input  logic [11:0] cam_z,
    input  logic [11:0] dx0,
    input  logic [11:0] dy0,
    input  logic [11:0] dz,
    input  logic [11:0] step_x,
    input  logic [11:0] step_y,
    output logic [11:0] ox,
    output logic [11:0] oy,
    output logic [11:0] oz,
    output logic [11:0] dx,
    output logic [11:0] dy,
    output logic [11:0] dz_out,
    output logic [7:0]  px,
    output logic [7:0]  py,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic        ray_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a ray moves on any rising edge with ray_valid=1 and ray_ready=1.
    // ray_valid is a pure function of state, and the ray is held while ready is low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [11:0] r_cam_x;
    logic [11:0] r_cam_y;
    logic [11:0] r_cam_z;
    logic [11:0] r_dx0;
    logic [11:0] r_dz;
    logic [11:0] r_step_x;
    logic [11:0] r_step_y;
    logic [11:0] r_dx;
    logic [11:0] r_dy;
    logic [7:0]  r_px;
    logic [7:0]  r_py;

    logic        w_run;
    logic        w_xfer;
    logic        w_px_max;
    logic        w_py_max;
    logic        w_last;

    assign w_run    = (r_state == S_RUN);
    assign w_xfer   = w_run && ray_ready;
    assign w_px_max = (r_px == 8'(H_RES - 1));
    assign w_py_max = (r_py == 8'(V_RES - 1));
    assign w_last   = w_run && w_px_max && w_py_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_RUN;
            S_RUN:  if (w_xfer && w_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cam_x  <= 12'd0;
            r_cam_y  <= 12'd0;
            r_cam_z  <= 12'd0;
            r_dx0    <= 12'd0;
            r_dz     <= 12'd0;
            r_step_x <= 12'd0;
            r_step_y <= 12'd0;
            r_dx     <= 12'd0;
            r_dy     <= 12'd0;
            r_px     <= 8'd0;
            r_py     <= 8'd0;
        end else if (r_state == S_IDLE && start) begin
            r_cam_x  <= cam_x;
            r_cam_y  <= cam_y;
            r_cam_z  <= cam_z;
            r_dx0    <= dx0;
            r_dz     <= dz;
            r_step_x <= step_x;
            r_step_y <= step_y;
            r_dx     <= dx0;
            r_dy     <= dy0;
            r_px     <= 8'd0;
            r_py     <= 8'd0;
        end else if (w_xfer && !w_last) begin
            // Direction accumulates with plain 12-bit wrap; row change reloads dx.
            if (!w_px_max) begin
                r_px <= r_px + 8'd1;
                r_dx <= r_dx + r_step_x;
            end else begin
                r_px <= 8'd0;
                r_dx <= r_dx0;
                r_py <= r_py + 8'd1;
                r_dy <= r_dy - r_step_y;
            end
        end
    end

    assign ox          = r_cam_x;
    assign oy          = r_cam_y;
    assign oz          = r_cam_z;
    assign dz_out      = r_dz;
    assign dx          = r_dx;
    assign dy          = r_dy;
    assign px          = r_px;
    assign py          = r_py;
    assign ray_valid   = w_run;
    assign ray_last    = w_last;
    assign busy        = w_run;
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ray_generator.sv
// Directed bench for ray_generator: a frame model fills an expected-ray queue,
// and a negedge monitor pops and compares every transferred ray.
module tb_ray_generator;

    localparam int H = 8;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] cam_x, cam_y, cam_z;
    logic [11:0] dx0, dy0, dz;
    logic [11:0] step_x, step_y;
    logic [11:0] ox, oy, oz, dx, dy, dz_out;
    logic [7:0]  px, py;
    logic        ray_valid, ray_ready, ray_last, busy, done;
    logic [1:0]  dbg_state;

    ray_generator #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
        .dx0(dx0), .dy0(dy0), .dz(dz),
        .step_x(step_x), .step_y(step_y),
        .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz_out(dz_out),
        .px(px), .py(py),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_last(ray_last),
        .busy(busy), .done(done), .o_dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard entry: {ox, oy, oz, dz, px, py, dx, dy}
    logic [87:0] exp_q[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_frame(input logic [11:0] c_x, input logic [11:0] c_y,
                             input logic [11:0] c_z, input logic [11:0] d_z,
                             input logic [11:0] d_x0, input logic [11:0] d_y0,
                             input logic [11:0] s_x, input logic [11:0] s_y);
        logic [11:0] ax, ay;
        ay = d_y0;
        for (int y = 0; y < V; y++) begin
            ax = d_x0;
            for (int x = 0; x < H; x++) begin
                exp_q.push_back({c_x, c_y, c_z, d_z, 8'(x), 8'(y), ax, ay});
                ax = ax + s_x;
            end
            ay = ay - s_y;
        end
    endtask

    // monitor / scoreboard
    int          xfer_cnt = 0;
    int          frame_xfer = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          chk_mode = 0;
    logic        prev_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic [95:0] snap = '0;
    logic [87:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done_vs_last", 96'(done), 96'(prev_last));
            chk("ray_last_pos", 96'(ray_last), 96'(ray_valid && px == 8'(H-1) && py == 8'(V-1)));
            if (prev_stall)
                chk("hold", {7'd0, ox, oy, oz, dz_out, px, py, dx, dy, ray_last}, snap);
            if (ray_valid && ray_ready) begin
                chk("ray_expected", 96'(exp_q.size() != 0), 96'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ray", 96'({ox, oy, oz, dz_out, px, py, dx, dy}), 96'(e));
                end
                if (chk_mode == 1 && frame_xfer == 8)
                    chk("row_wrap", 96'({px, py, dx, dy}), 96'({8'd0, 8'd1, 12'hFC0, 12'h030}));
                if (chk_mode == 1 && frame_xfer == 9)
                    chk("ray9", 96'({px, py, dx, dy}), 96'({8'd1, 8'd1, 12'hFD0, 12'h030}));
                if (chk_mode == 2 && frame_xfer == 1)
                    chk("dx_wrap", 96'(dx), 96'(12'h810));
                if (frame_xfer == 0) first_cyc = cyc;
                if (ray_last) last_cyc = cyc;
                xfer_cnt++;
                frame_xfer++;
            end
            prev_stall = ray_valid && !ray_ready;
            snap       = {7'd0, ox, oy, oz, dz_out, px, py, dx, dy, ray_last};
            prev_last  = ray_valid && ray_ready && ray_last;
        end
    end

    // driver tasks
    task automatic start_frame();
        @(posedge clk); #1;
        start = 1'b1;
        frame_xfer = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_valid", 96'(ray_valid), 96'(1));
        chk("latency_pos", 96'({px, py}), 96'(0));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 96'(n < budget), 96'(1));
    endtask

    task automatic wait_pixel(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        while (!(ray_valid && px == x && py == y) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_pixel", 96'(n < 200), 96'(1));
    endtask

    int base;

    initial begin
        rst_n = 1'b0; start = 1'b0; ray_ready = 1'b0;
        cam_x = 12'h111; cam_y = 12'h222; cam_z = 12'h333;
        dx0 = 12'h444; dy0 = 12'h555; dz = 12'h666;
        step_x = 12'h001; step_y = 12'h001;
        #12;
        chk("reset_ray", 96'({ox, oy, oz, dx, dy, dz_out, px, py}), 96'(0));
        chk("reset_ctrl", 96'({ray_valid, busy, done, ray_last}), 96'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("idle_no_start", 96'({busy, ray_valid}), 96'(0));

        // frame test
        cam_x = 12'h123; cam_y = 12'h0A5; cam_z = 12'hF80; dz = 12'h010;
        dx0 = 12'hFC0; dy0 = 12'h040; step_x = 12'h010; step_y = 12'h010;
        ray_ready = 1'b1;
        chk_mode = 1;
        base = xfer_cnt;
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        start_frame();
        wait_done(300);
        chk("f1_count", 96'(xfer_cnt - base), 96'(64));
        chk("f1_consecutive", 96'(last_cyc - first_cyc), 96'(63));
        chk("f1_queue_empty", 96'(exp_q.size()), 96'(0));
        @(posedge clk); #1;
        chk("f1_idle", 96'({busy, done}), 96'(0));

        // backpressure test
        chk_mode = 0;
        cam_x = 12'h0F0; dx0 = 12'h020; dy0 = 12'hF00; step_x = 12'h003; step_y = 12'h005;
        base = xfer_cnt;
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        start_frame();
        wait_pixel(8'd3, 8'd2);
        ray_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_held_pos", 96'({ray_valid, px, py}), 96'({1'b1, 8'd3, 8'd2}));
        ray_ready = 1'b1;
        wait_done(300);
        chk("f2_count", 96'(xfer_cnt - base), 96'(64));
        chk("f2_queue_empty", 96'(exp_q.size()), 96'(0));

        // mid-frame reset test
        @(posedge clk); #1;
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        start_frame();
        wait_pixel(8'd4, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ray", 96'({ox, oy, oz, dx, dy, dz_out, px, py}), 96'(0));
        chk("async_reset_ctrl", 96'({ray_valid, busy, done, ray_last}), 96'(0));
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("post_reset_idle", 96'({busy, ray_valid, done}), 96'(0));
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        start_frame();
        wait_done(300);
        chk("f3_queue_empty", 96'(exp_q.size()), 96'(0));

        // start-ignore, input-change and dx wrap test, start held high
        @(posedge clk); #1;
        chk_mode = 2;
        cam_x = 12'h050; cam_y = 12'h060; cam_z = 12'h070; dz = 12'h008;
        dx0 = 12'h7F0; dy0 = 12'h100; step_x = 12'h020; step_y = 12'h030;
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        start = 1'b1;
        frame_xfer = 0;
        repeat (6) begin @(posedge clk); #1; end
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        cam_x = 12'hABC; dx0 = 12'h001; step_x = 12'hFFF; step_y = 12'h002;
        gen_frame(cam_x, cam_y, cam_z, dz, dx0, dy0, step_x, step_y);
        chk("run_origin_kept", 96'(ox), 96'(12'h050));
        wait_done(300);
        @(posedge clk); #1;
        chk("idle_after_done", 96'(busy), 96'(0));
        @(posedge clk); #1;
        chk("restart_held_start", 96'({busy, px, py, ox}), 96'({1'b1, 8'd0, 8'd0, 12'hABC}));
        start = 1'b0;
        chk_mode = 0;
        wait_done(300);
        chk("f5_queue_empty", 96'(exp_q.size()), 96'(0));
        repeat (3) @(posedge clk); #1;
        chk("final_idle", 96'({busy, ray_valid, done}), 96'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
